// File: rtl/prbs_pkg.sv
// Shared types and constants for the framed PRBS-15 scrambler.
// Imported by the LFSR core and the frame sequencer.
package prbs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HDR,
      PAY,
      DONE
   } state_t;

   localparam int TAP_HI = 14;
   localparam int TAP_LO = 13;

   localparam logic [14:0] DEF_SEED = 15'h4A80;

   // An all-zero seed would lock the LFSR, so fall back to the default.
   function automatic logic [14:0] fix_seed(
      input logic [14:0] s,
      input logic [14:0] dflt
   );
      return (s == 15'd0) ? dflt : s;
   endfunction

endpackage

// File: rtl/prbs15_core.sv
// x^15+x^14+1 LFSR with synchronous load and step.
// fb is the combinational feedback bit of the current state.
module prbs15_core
   import prbs_pkg::*;
#(
   parameter logic [14:0] SEED = DEF_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [14:0] seed,
   input  logic        step,
   output logic        fb
);

   logic [14:0] s;

   assign fb = s[TAP_HI] ^ s[TAP_LO];

   // Load takes priority over step; otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= SEED;
      end else if (load) begin
         s <= seed;
      end else if (step) begin
         s <= {s[13:0], fb};
      end
   end

endmodule

// File: rtl/prbs_frame_sequencer.sv
// Frames a sync header plus PRBS-15 scrambled payload.
// LFSR is re-seeded at each frame start.
module prbs_frame_sequencer
   import prbs_pkg::*;
#(
   parameter logic [14:0] SEED        = DEF_SEED,
   parameter int          HDR_BITS    = 8,
   parameter logic [15:0] HDR_PATTERN = 16'h00A5,
   parameter int          LEN_W       = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             seed_sel,
   input  logic [14:0]      seed_in,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   output logic             out_bit,
   output logic             out_last,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] HDR_LAST = 4'(HDR_BITS - 1);

   state_t           state;
   logic [LEN_W-1:0] rem;
   logic [3:0]       hdr_cnt;
   logic [3:0]       hdr_idx;
   logic [14:0]      seed_r;
   logic             lfsr_load;
   logic             lfsr_step;
   logic             fb;

   assign in_ready  = (state == PAY);
   assign busy      = (state != IDLE);
   assign lfsr_load = (state == LOAD);
   assign lfsr_step = (state == PAY) && in_valid;
   assign hdr_idx   = HDR_LAST - hdr_cnt;

   prbs15_core #(
      .SEED (SEED)
   ) u_core (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .seed (seed_r),
      .step (lfsr_step),
      .fb   (fb)
   );

   // Frame FSM with registered line-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rem       <= '0;
         hdr_cnt   <= '0;
         seed_r    <= SEED;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rem    <= len;
                  seed_r <= fix_seed(seed_sel ? seed_in : SEED, SEED);
                  state  <= LOAD;
               end
            end
            LOAD: begin
               hdr_cnt <= '0;
               state   <= HDR;
            end
            HDR: begin
               out_valid <= 1'b1;
               out_bit   <= HDR_PATTERN[hdr_idx];
               if (hdr_cnt == HDR_LAST) begin
                  if (rem == '0) begin
                     out_last <= 1'b1;
                     state    <= DONE;
                  end else begin
                     state <= PAY;
                  end
               end else begin
                  hdr_cnt <= hdr_cnt + 4'd1;
               end
            end
            PAY: begin
               if (in_valid) begin
                  out_valid <= 1'b1;
                  out_bit   <= in_bit ^ fb;
                  rem       <= rem - LEN_W'(1);
                  if (rem == LEN_W'(1)) begin
                     out_last <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prbs_frame_sequencer.sv
// Directed bench for prbs_frame_sequencer.
// Frame vectors in a table plus hand-written reset sequences.
module tb_prbs_frame_sequencer;

   localparam int HB = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] len;
   logic       seed_sel;
   logic [14:0] seed_in;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       out_valid;
   logic       out_bit;
   logic       out_last;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   prbs_frame_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .seed_sel  (seed_sel),
      .seed_in   (seed_in),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endtask

   // Negedge monitor
   bit mon_en = 1'b0;
   int ncyc = 0;
   int vcyc[$];
   bit vbit[$];
   int acc_cyc[$];
   int last_n, last_cyc, last_idx;
   int done_n, done_cyc, ir_n;

   always @(negedge clk) begin
      ncyc++;
      if (mon_en) begin
         if (out_valid) begin
            vcyc.push_back(ncyc);
            vbit.push_back(out_bit);
         end
         if (out_last) begin
            last_n++;
            last_cyc = ncyc;
            last_idx = vbit.size();
         end
         if (done) begin
            done_n++;
            done_cyc = ncyc;
         end
         if (in_ready) ir_n++;
         if (in_ready && in_valid) acc_cyc.push_back(ncyc);
      end
   end

   task automatic mon_clear();
      vcyc.delete();
      vbit.delete();
      acc_cyc.delete();
      last_n = 0; last_cyc = 0; last_idx = 0;
      done_n = 0; done_cyc = 0; ir_n = 0;
   endtask

   typedef struct {
      bit          sel;
      logic [14:0] sd;
      int          len;
      logic [31:0] din;
      logic [31:0] dout;
      bit          stall;
      bit          restart;
   } vec_t;

   vec_t vt[6];

   task automatic run_frame(input vec_t v, input string tag);
      int st, acc, lim, bad;
      bit take;
      logic [31:0] got;
      mon_clear();
      mon_en = 1'b1;
      @(posedge clk); #1;
      seed_sel = v.sel;
      seed_in  = v.sd;
      len      = 10'(v.len);
      start    = 1'b1;
      in_valid = 1'b1;
      in_bit   = v.din[0];
      st  = ncyc;
      acc = 0;
      @(posedge clk); #1;
      start = 1'b0;
      lim = 0;
      while (done_n == 0 && lim < 300) begin
         @(negedge clk);
         take = in_valid && in_ready;
         @(posedge clk); #1;
         lim++;
         if (take) acc++;
         in_valid = !(v.stall && take);
         in_bit   = (acc < 32) ? v.din[acc] : 1'b0;
         start    = v.restart && (lim == 3 || lim == HB + 5);
      end
      start = 1'b0;
      repeat (v.restart ? 30 : 5) @(posedge clk);
      #1;
      mon_en = 1'b0;
      chk({tag, " done_count"}, done_n, 1);
      got = '0;
      for (int i = 0; i < HB; i++)
         if (i < vbit.size()) got = {got[30:0], vbit[i]};
      chk({tag, " header"}, int'(got), 'hA5);
      if (vcyc.size() >= HB) begin
         chk({tag, " hdr_latency"}, vcyc[0] - st, 4);
         chk({tag, " hdr_gapless"}, vcyc[HB-1] - vcyc[0], HB - 1);
      end else begin
         chk({tag, " hdr_count"}, vcyc.size(), HB);
      end
      chk({tag, " valid_bits"}, vbit.size(), HB + v.len);
      got = '0;
      for (int i = 0; i < v.len; i++)
         if (HB + i < vbit.size()) got[i] = vbit[HB+i];
      chk({tag, " payload"}, int'(got), int'(v.dout));
      chk({tag, " accepted"}, acc_cyc.size(), v.len);
      bad = 0;
      for (int i = 0; i < v.len; i++)
         if (i < acc_cyc.size() && HB + i < vcyc.size())
            if (vcyc[HB+i] != acc_cyc[i] + 1) bad++;
      chk({tag, " pay_latency_errs"}, bad, 0);
      chk({tag, " last_count"}, last_n, 1);
      chk({tag, " last_pos"}, last_idx, HB + v.len);
      chk({tag, " done_after_last"}, done_cyc - last_cyc, 1);
      if (v.len == 0) chk({tag, " in_ready_never"}, ir_n, 0);
   endtask

   initial begin
      int bad, cnt, lim;
      // seed 1 -> keystream 13 zeros then a 1
      // SEED keystream: 1011111100000011 1000
      vt[0] = '{1'b0, 15'h0000,  0, 32'h0,     32'h0,     1'b0, 1'b0};
      vt[1] = '{1'b1, 15'h0001, 14, 32'h0,     32'h2000,  1'b0, 1'b0};
      vt[2] = '{1'b1, 15'h0000, 20, 32'h0,     32'h1C0FD, 1'b1, 1'b0};
      vt[3] = '{1'b0, 15'h1234, 20, 32'hFFFFF, 32'hE3F02, 1'b0, 1'b1};
      vt[4] = '{1'b1, 15'h0001,  3, 32'h5,     32'h5,     1'b0, 1'b0};
      vt[5] = '{1'b0, 15'h0000,  1, 32'h1,     32'h0,     1'b0, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      len = '0;
      seed_sel = 1'b0;
      seed_in = '0;
      in_valid = 1'b0;
      in_bit = 1'b0;
      #13;
      chk("in_reset_outs",
          int'({in_ready, out_valid, out_bit, out_last, busy, done}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if ({in_ready, out_valid, out_bit, out_last, busy, done} != 6'd0)
            bad++;
      end
      chk("idle_nonzero_cycles", bad, 0);

      for (int k = 0; k < 6; k++) run_frame(vt[k], $sformatf("v%0d", k));

      // Reset while the 5th payload bit is on the line
      mon_clear();
      mon_en = 1'b1;
      @(posedge clk); #1;
      seed_sel = 1'b1;
      seed_in  = 15'h0001;
      len      = 10'd14;
      in_valid = 1'b1;
      in_bit   = 1'b0;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      lim = 0;
      while (cnt < HB + 5 && lim < 100) begin
         @(negedge clk);
         if (out_valid) cnt++;
         lim++;
      end
      chk("rst_reached_pay5", cnt, HB + 5);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_mid_outs",
          int'({in_ready, out_valid, out_bit, out_last, busy, done}), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("rst_no_done", done_n, 0);
      chk("rst_no_last", last_n, 0);
      mon_en = 1'b0;

      run_frame(vt[1], "post_rst");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
